// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// video_timing_gen : raster timing generator (HSYNC/VSYNC/DE, X/Y, frame count)
// Revision: 1.0
// ============================================================================
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          PCLK,
  input  logic          RESET,
  input  logic          EN,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          DE,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic [15:0]   FRAME_CNT
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Thresholds carry one extra bit so a total of exactly 2^CW still compares correctly.
  localparam logic [CW:0] C_H_LAST = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] C_V_LAST = (CW+1)'(V_TOTAL - 1);
  localparam logic [CW:0] C_H_ACT  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] C_V_ACT  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] C_HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] C_HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] C_VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] C_VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic          run_d;
  logic [CW:0]   x_ext_d;
  logic [CW:0]   y_ext_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fcnt_d  = fcnt_q;

    if (!EN) begin
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
      x_d     = '0;
      y_d     = '0;
    end else if ({1'b0, x_q} == C_H_LAST) begin
      x_d = '0;
      if ({1'b0, y_q} == C_V_LAST) begin
        y_d    = '0;
        fcnt_d = fcnt_q + 16'd1;
      end else begin
        y_d = y_q + CW'(1);
      end
    end else begin
      x_d = x_q + CW'(1);
    end

    // Outputs are decoded from the next position so they register alongside X/Y.
    run_d   = (state_d == ST_RUN);
    x_ext_d = {1'b0, x_d};
    y_ext_d = {1'b0, y_d};
    de_d    = run_d && (x_ext_d < C_H_ACT) && (y_ext_d < C_V_ACT);
    hs_d    = (run_d && (x_ext_d >= C_HS_BEG) && (x_ext_d < C_HS_END)) ? HS_POL : ~HS_POL;
    vs_d    = (run_d && (y_ext_d >= C_VS_BEG) && (y_ext_d < C_VS_END)) ? VS_POL : ~VS_POL;
    ls_d    = run_d && (x_d == '0);
    fs_d    = ls_d && (y_d == '0);
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      fcnt_q  <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fcnt_q  <= fcnt_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign HSYNC       = hs_q;
  assign VSYNC       = vs_q;
  assign DE          = de_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;
  assign FRAME_CNT   = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// tb_video_timing_gen : random EN/RESET stimulus against a pixel-index raster model,
// plus a one-pixel-frame instance that exercises the 16-bit frame counter wrap.
module tb_video_timing_gen;

  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 2, VF = 1, VSW = 1, VB = 1;
  localparam bit HP = 1'b1, VP = 1'b1;
  localparam int CW = 12;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          hsync, vsync, de, ls, fs;
  logic [CW-1:0] x, y;
  logic [15:0]   fcnt;

  logic          w_rst = 1'b1;
  logic          w_en  = 1'b1;
  logic          w_hsync, w_vsync, w_de, w_ls, w_fs;
  logic [CW-1:0] w_x, w_y;
  logic [15:0]   w_fcnt;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .CW(CW)
  ) dut (
    .PCLK(clk), .RESET(rst), .EN(en),
    .HSYNC(hsync), .VSYNC(vsync), .DE(de), .X(x), .Y(y),
    .LINE_START(ls), .FRAME_START(fs), .FRAME_CNT(fcnt)
  );

  video_timing_gen #(
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) u_wrap (
    .PCLK(clk), .RESET(w_rst), .EN(w_en),
    .HSYNC(w_hsync), .VSYNC(w_vsync), .DE(w_de), .X(w_x), .Y(w_y),
    .LINE_START(w_ls), .FRAME_START(w_fs), .FRAME_CNT(w_fcnt)
  );

  typedef struct {
    logic hs, vs, de, ls, fs;
    int   x, y, fcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   wrap_done = 1'b0;

  // Reference model: a running pixel index since the last start plus a completed-frame base.
  bit m_run  = 1'b0;
  int m_t    = 0;
  int m_base = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   px, py;
    if (!m_run) begin
      e.x = 0; e.y = 0; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
      e.hs = ~HP; e.vs = ~VP;
      e.fcnt = m_base & 32'hFFFF;
    end else begin
      px = m_t % HT;
      py = (m_t / HT) % VT;
      e.x  = px;
      e.y  = py;
      e.de = (px < HA) && (py < VA);
      e.hs = (px >= HA + HF && px < HA + HF + HSW) ? HP : ~HP;
      e.vs = (py >= VA + VF && py < VA + VF + VSW) ? VP : ~VP;
      e.ls = (px == 0);
      e.fs = (px == 0) && (py == 0);
      e.fcnt = (m_base + m_t / FRAME) & 32'hFFFF;
    end
    return e;
  endfunction

  task automatic model_step(input logic r, input logic e);
    if (r) begin
      m_run = 1'b0; m_base = 0;
    end else if (!e) begin
      if (m_run) m_base = (m_base + m_t / FRAME) & 32'hFFFF;
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  // Monitor: every cycle the DUT presents a position; compare it with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("X",           32'(x),     32'(e.x));
        check("Y",           32'(y),     32'(e.y));
        check("DE",          32'(de),    32'(e.de));
        check("HSYNC",       32'(hsync), 32'(e.hs));
        check("VSYNC",       32'(vsync), 32'(e.vs));
        check("LINE_START",  32'(ls),    32'(e.ls));
        check("FRAME_START", 32'(fs),    32'(e.fs));
        check("FRAME_CNT",   32'(fcnt),  32'(e.fcnt));
      end
    end
  end

  // Frame counter wrap: one-pixel frames, so every RUN edge after the first completes a frame.
  initial begin
    w_rst = 1'b1; w_en = 1'b1;
    @(negedge clk);
    w_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("WRAP_CNT_ONE", 32'(w_fcnt), 32'd1);
    repeat (65534) @(posedge clk);
    #1 check("WRAP_CNT_FFFF", 32'(w_fcnt), 32'hFFFF);
    check("WRAP_FRAME_START", 32'(w_fs), 32'd1);
    @(posedge clk);
    #1 check("WRAP_CNT_0000", 32'(w_fcnt), 32'd0);
    wrap_done = 1'b1;
  end

  // Stimulus: reset, three clean frames, then random EN drops and asynchronous reset pulses.
  initial begin
    int en_low;
    en_low = 0;
    if (HT > 2 ** CW || VT > 2 ** CW) begin
      errors++;
      $display("FAIL param_legality: H_TOTAL %0d V_TOTAL %0d exceed 2^%0d", HT, VT, CW);
    end
    rst = 1'b1; en = 1'b0;
    for (int c = 0; c < 4200; c++) begin
      @(posedge clk);
      model_step(rst, en);
      sb.push_back(model_out());
      #2;
      if (c == 2) rst = 1'b0;
      if (c < 2) begin
        en = 1'b0;
      end else if (c < 140) begin
        en = 1'b1;
      end else if (en_low > 0) begin
        en = 1'b0;
        en_low--;
      end else if ($urandom_range(0, 99) < 3) begin
        en = 1'b0;
        en_low = $urandom_range(0, 5);
      end else begin
        en = 1'b1;
      end
      if (c > 140 && $urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        void'(sb.pop_back());
        m_run = 1'b0; m_base = 0;
        sb.push_back(model_out());
        #5 rst = 1'b0;
      end
    end
    @(negedge clk);
    #1 check("SB_DRAINED", 32'(sb.size()), 32'd0);
    wait (wrap_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL provide parameter H_FP, default 16, horizontal front porch, pixels.
REQ-003 SHALL provide parameter H_SYNC, default 96, horizontal sync width, pixels.
REQ-004 SHALL provide parameter H_BP, default 48, horizontal back porch, pixels.
REQ-005 SHALL provide parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL provide parameter V_FP, default 10, vertical front porch, lines.
REQ-007 SHALL provide parameter V_SYNC, default 2, vertical sync width, lines.
REQ-008 SHALL provide parameter V_BP, default 33, vertical back porch, lines.
REQ-009 SHALL provide parameter HS_POL, default 0, HSYNC active level (0 = active-low).
REQ-010 SHALL provide parameter VS_POL, default 0, VSYNC active level (0 = active-low).
REQ-011 SHALL provide parameter CW, default 12, width of X/Y position outputs.
REQ-012 SHALL have ports: PCLK  in  1  pixel clock, sole clock, all logic on rising edge.
REQ-013 RESET  in  1  reset; asynchronous and active-high.
REQ-014 EN  in  1  run enable (tied to PLOCK at top level).
REQ-015 HSYNC  out  1  horizontal sync, polarity per HS_POL.
REQ-016 VSYNC  out  1  vertical sync, polarity per VS_POL.
REQ-017 DE  out  1  display enable, high in active area only.
REQ-018 X  out  CW  horizontal position, 0..H_TOTAL-1.
REQ-019 Y  out  CW  vertical position, 0..V_TOTAL-1.
REQ-020 LINE_START  out  1  one-cycle pulse at X=0 of every line.
REQ-021 FRAME_START  out  1  one-cycle pulse at X=0,Y=0.
REQ-022 FRAME_CNT  out  16  completed-frame counter.

Function
REQ-023 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; line order active, front porch, sync, back porch.
REQ-024 Block SHALL have two states: IDLE (no valid position) and RUN.
REQ-025 IDLE->RUN on rising PCLK edge with EN=1; that edge SHALL load position (0,0) and outputs SHALL reflect (0,0) in the following cycle.
REQ-026 In RUN, each PCLK edge with EN=1: X<=X+1; at X=H_TOTAL-1, X<=0 and Y advances; at Y=V_TOTAL-1 with X wrap, Y<=0.
REQ-027 RUN->IDLE on any PCLK edge with EN=0 (synchronous); mid-frame loss of EN abandons the frame, FRAME_CNT unchanged.
REQ-028 All outputs SHALL be registered and mutually aligned: in any cycle every output describes the position currently on X/Y; no additional latency.
REQ-029 DE=1 iff RUN and X<H_ACTIVE and Y<V_ACTIVE.
REQ-030 HSYNC=HS_POL iff RUN and H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-031 VSYNC=VS_POL iff RUN and V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC (whole lines, changing at X=0), else ~VS_POL.
REQ-032 LINE_START=1 iff RUN and X=0; FRAME_START=1 iff RUN and X=0 and Y=0.
REQ-033 FRAME_CNT SHALL increment by 1 on the edge wrapping (H_TOTAL-1,V_TOTAL-1)->(0,0); modulo 2^16 wrap, 0xFFFF->0x0000.
REQ-034 In IDLE: X=0, Y=0, DE=0, LINE_START=0, FRAME_START=0, syncs inactive, FRAME_CNT held.
REQ-035 Parameter values with H_TOTAL or V_TOTAL > 2^CW are illegal; behaviour undefined, bench SHALL flag.

Reset
REQ-036 RESET=1 SHALL immediately, independent of PCLK, force IDLE, X=0, Y=0, DE=0, LINE_START=0, FRAME_START=0, HSYNC=~HS_POL, VSYNC=~VS_POL, FRAME_CNT=0.
REQ-037 After RESET deasserts, first PCLK edge with EN=1 performs REQ-025; reset mid-frame discards position.

Verification
REQ-038 Defaults, RESET release, EN=1 -> FRAME_START and DE high first cycle at (0,0); next FRAME_START exactly 420000 cycles later; FRAME_CNT=1 then.
REQ-039 Defaults, one line -> DE high 640 cycles (X 0..639), HSYNC low X 656..751 (96 cycles), LINE_START every 800 cycles.
REQ-040 Defaults, one frame -> VSYNC low exactly lines 490..491 (1600 cycles), DE never high for Y>=480, Y wraps 524->0.
REQ-041 EN dropped at (300,200) for 5 cycles -> IDLE values per REQ-034 next cycle; on EN return restart at (0,0), FRAME_CNT unchanged.
REQ-042 RESET pulsed asynchronously between PCLK edges mid-line -> outputs reach REQ-036 values before next edge; FRAME_CNT=0.
REQ-043 Param H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=2,V_FP=1,V_SYNC=1,V_BP=1,HS_POL=1,VS_POL=1, FRAME_CNT preloaded near 0xFFFF via 65536 frames -> frame period 40 cycles, HSYNC high X=5..6, VSYNC high Y=3, FRAME_CNT 0xFFFF->0x0000.
